mac_sequencer: RTL and testbench
================================

// Module: mac_sequencer
// PURPOSE
//  Sequences the multi-cycle multiply-accumulate unit in the EX stage and owns the 32-bit accumulator.
//  It stalls IF/ID/EX while a MAC instruction computes its result.
//  It drives mac_out and mac_control_mem to the MEM-stage result selector, which forwards mac_out
//  instead of the normal memory mux output. Accepts one MAC instruction at a time.
// PARAMETERS
//  DATA_W       32  operand, product and accumulator width
//  MAC_LATENCY  4   multiplier cycles per MAC (>=1); counter width $clog2(MAC_LATENCY)+1
// PORTS
//  clk              in   1       rising-edge clock
//  reset            in   1       synchronous, active-high
//  mac_issue        in   1       EX holds a MAC/MUL instruction
//  mac_clr          in   1       with mac_issue: 1 = acc<=a*b (MUL), 0 = acc<=acc+a*b (MAC)
//  op_a             in   DATA_W  EX operand A
//  op_b             in   DATA_W  EX operand B
//  flush            in   1       squash EX instruction (branch/exception)
//  pipe_advance     in   1       EX/MEM and MEM/WB regs update this cycle (independent of stall_ex)
//  stall_ex         out  1       freeze IF/ID/EX; hazard unit inserts MEM bubble
//  mac_busy         out  1       state != IDLE
//  mac_out          out  DATA_W  accumulator value to MEM result selector
//  mac_control_mem  out  1       MAC result occupies MEM; selector picks mac_out
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, acc=0, latched operands=0; all outputs 0.
//    Reset mid-operation aborts it, with no acc update.
//  States: IDLE, BUSY, DONE, RESULT.
//  IDLE: on mac_issue & !flush, latch op_a/op_b/mac_clr, set cnt=MAC_LATENCY-1, go to BUSY.
//    stall_ex=1 combinationally in that cycle.
//  BUSY: stall_ex=1; cnt decrements each cycle.
//    At cnt==0: acc <= (clr ? 0 : acc) + lo32(a*b), unsigned, wraps mod 2^32; go to DONE.
//    flush in BUSY: go to IDLE, acc unchanged, stall_ex=0 that cycle.
//  DONE: stall_ex=0 (instruction leaves EX). pipe_advance=1 -> RESULT; else hold.
//    flush in DONE -> IDLE, with acc already updated (commit point is end of BUSY).
//  RESULT: mac_control_mem=1, held while pipe_advance=0.
//    On pipe_advance=1 -> IDLE.
//    If mac_issue is set during RESULT: stall_ex=1. It is captured only in the following IDLE cycle.
//  Timing: issue cycle T. stall_ex high T..T+MAC_LATENCY (MAC_LATENCY+1 cycles). acc valid from T+L+1.
//    With pipe_advance=1, mac_control_mem is high exactly at cycle T+L+2.
//  mac_out = acc at all times. It is registered and stable throughout RESULT.
//  mac_issue in BUSY/DONE is ignored (EX is frozen, so it is the same instruction).
//  flush with mac_issue in IDLE: not accepted, stall_ex=0.
//  MAC_LATENCY=1: BUSY lasts exactly 1 cycle.
// TESTING
//  1 Reset: hold reset 3 cycles -> stall_ex=0, mac_busy=0, mac_control_mem=0, mac_out=0.
//  2 MUL: L=4, issue clr=1, a=3, b=5, pipe_advance=1 -> stall_ex high 5 cycles, mac_out=15,
//    mac_control_mem high exactly 1 cycle at T+6.
//  3 MAC: then issue clr=0, a=7, b=2 -> mac_out=29; then clr=0, a=0x10000, b=0x10000 -> mac_out=29 (low 32 bits of 2^32 add 0).
//  4 Wrap: clr=1, a=0xFFFFFFFF, b=1 -> 0xFFFFFFFF; then clr=0, a=1, b=1 -> mac_out=0.
//  5 Flush: acc=29, issue a=2, b=2, assert flush in 2nd BUSY cycle -> IDLE, mac_out=29,
//    stall_ex=0 that cycle, no mac_control_mem pulse.
//    Then reset asserted in 3rd BUSY cycle of a new MAC -> IDLE, acc=0.
//  6 MEM hold: in RESULT hold pipe_advance=0 for 3 cycles with mac_issue=1 ->
//    mac_control_mem stays 1, stall_ex=1, new MAC starts only in the IDLE cycle after advance.

Source files
------------

// File: rtl/mac_sequencer.sv
// Multi-cycle multiply-accumulate sequencer for the EX stage: owns the accumulator,
// stalls IF/ID/EX while a product is computed and flags the MAC result to MEM.
module mac_sequencer #(
  parameter int DATA_W      = 32,
  parameter int MAC_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mac_issue,
  input  logic              mac_clr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  input  logic              pipe_advance,
  output logic              stall_ex,
  output logic              mac_busy,
  output logic [DATA_W-1:0] mac_out,
  output logic              mac_control_mem
);
  localparam int CNT_W = $clog2(MAC_LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, RESULT} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              clr_q;
  logic [DATA_W-1:0] prod_lo;
  logic [DATA_W-1:0] acc_d;

  // Only the low DATA_W bits of the product are kept, so accumulation wraps naturally.
  assign prod_lo = a_q * b_q;
  assign acc_d   = (clr_q ? '0 : acc_q) + prod_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      clr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mac_issue && !flush) begin
            a_q     <= op_a;
            b_q     <= op_b;
            clr_q   <= mac_clr;
            cnt_q   <= CNT_W'(MAC_LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            acc_q   <= acc_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        // The accumulator is already committed here, so a flush only drops the MEM pulse.
        DONE: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (pipe_advance) begin
            state_q <= RESULT;
          end
        end
        RESULT: begin
          if (pipe_advance) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A MAC arriving while the previous result still sits in MEM must wait for the next IDLE.
  always_comb begin
    stall_ex = 1'b0;
    case (state_q)
      IDLE:    stall_ex = mac_issue && !flush;
      BUSY:    stall_ex = !flush;
      DONE:    stall_ex = 1'b0;
      RESULT:  stall_ex = mac_issue;
      default: stall_ex = 1'b0;
    endcase
    if (reset) begin
      stall_ex = 1'b0;
    end
  end

  assign mac_busy        = (state_q != IDLE);
  assign mac_control_mem = (state_q == RESULT);
  assign mac_out         = acc_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: directed vector table, flush/reset/MEM-hold sequences and
// randomized MAC/MUL streams checked cycle by cycle against a transaction-level model.
module tb_mac_sequencer;
  localparam int DW = 32;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          mac_issue;
  logic          mac_clr;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          flush;
  logic          pipe_advance;
  logic          stall_ex;
  logic          mac_busy;
  logic [DW-1:0] mac_out;
  logic          mac_control_mem;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_txn    = 0;
  logic [DW-1:0] model_acc;

  typedef struct {
    logic          clr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  mac_sequencer #(.DATA_W(DW), .MAC_LATENCY(L)) dut (
    .clk             (clk),
    .reset           (reset),
    .mac_issue       (mac_issue),
    .mac_clr         (mac_clr),
    .op_a            (op_a),
    .op_b            (op_b),
    .flush           (flush),
    .pipe_advance    (pipe_advance),
    .stall_ex        (stall_ex),
    .mac_busy        (mac_busy),
    .mac_out         (mac_out),
    .mac_control_mem (mac_control_mem)
  );

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One MAC/MUL from its issue cycle (k=0) until it leaves MEM. hold = RESULT cycles
  // with pipe_advance low; nxt = a following MAC waits in EX during RESULT.
  task automatic run_mac(input string tag, input logic clr, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] exp,
                         input int hold, input logic nxt);
    logic [DW-1:0] old;
    logic          in_res;
    int            last;
    old  = model_acc;
    last = L + 2 + hold;
    for (int k = 0; k <= last; k++) begin
      in_res       = (k >= L + 2);
      mac_issue    = (k <= L) || (in_res && nxt);
      mac_clr      = clr;
      op_a         = in_res ? DW'($urandom) : a;
      op_b         = in_res ? DW'($urandom) : b;
      flush        = 1'b0;
      pipe_advance = !(in_res && (k < last));
      @(negedge clk);
      check($sformatf("%s k%0d stall_ex", tag, k), DW'(stall_ex),
            DW'((k <= L) || (in_res && nxt)));
      check($sformatf("%s k%0d mac_busy", tag, k), DW'(mac_busy), DW'(k >= 1));
      check($sformatf("%s k%0d mac_control_mem", tag, k), DW'(mac_control_mem), DW'(in_res));
      check($sformatf("%s k%0d mac_out", tag, k), mac_out, (k >= L + 1) ? exp : old);
      next_cycle();
    end
    mac_issue = 1'b0;
    model_acc = exp;
    n_txn++;
    $display("txn %0d %s clr=%0d a=%h b=%h hold=%0d mac_out=%h expected=%h",
             n_txn, tag, clr, a, b, hold, mac_out, exp);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      mac_issue    = 1'b0;
      flush        = 1'b0;
      pipe_advance = 1'b1;
      @(negedge clk);
      check($sformatf("%s idle%0d mac_busy", tag, k), DW'(mac_busy), '0);
      check($sformatf("%s idle%0d stall_ex", tag, k), DW'(stall_ex), '0);
      check($sformatf("%s idle%0d mac_control_mem", tag, k), DW'(mac_control_mem), '0);
      check($sformatf("%s idle%0d mac_out", tag, k), mac_out, model_acc);
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          r_clr;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_exp;

    vecs[0] = '{1'b1, 32'd3,        32'd5,        32'd15};
    vecs[1] = '{1'b0, 32'd7,        32'd2,        32'd29};
    vecs[2] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'd29};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 32'd1,        32'd1,        32'd0};
    vecs[5] = '{1'b1, 32'd29,       32'd1,        32'd29};

    reset = 1'b1; mac_issue = 1'b0; mac_clr = 1'b0; op_a = '0; op_b = '0;
    flush = 1'b0; pipe_advance = 1'b0; model_acc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall_ex", DW'(stall_ex), '0);
    check("reset mac_busy", DW'(mac_busy), '0);
    check("reset mac_control_mem", DW'(mac_control_mem), '0);
    check("reset mac_out", mac_out, '0);
    next_cycle();
    reset = 1'b0;
    idle_cycles("post_reset", 2);

    for (int i = 0; i < 6; i++) begin
      run_mac($sformatf("vec%0d", i), vecs[i].clr, vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1'b0);
      idle_cycles($sformatf("vec%0d", i), 1);
    end

    // Flush in the second BUSY cycle: no commit, no MEM pulse.
    for (int k = 0; k <= 3; k++) begin
      mac_issue = (k <= 2); mac_clr = 1'b0; op_a = 32'd2; op_b = 32'd2;
      flush = (k == 2); pipe_advance = 1'b1;
      @(negedge clk);
      if (k == 1) check("flush busy1 stall_ex", DW'(stall_ex), 32'd1);
      if (k == 2) check("flush cycle stall_ex", DW'(stall_ex), '0);
      if (k == 3) check("flush after mac_busy", DW'(mac_busy), '0);
      check($sformatf("flush k%0d mac_out", k), mac_out, 32'd29);
      check($sformatf("flush k%0d mac_control_mem", k), DW'(mac_control_mem), '0);
      next_cycle();
    end
    idle_cycles("flush", 4);
    $display("txn flush: mac_out=%h expected=%h", mac_out, model_acc);

    // Reset in the third BUSY cycle: abort, accumulator cleared.
    for (int k = 0; k <= 4; k++) begin
      mac_issue = (k <= 3); mac_clr = 1'b0; op_a = 32'd3; op_b = 32'd3;
      flush = 1'b0; pipe_advance = 1'b1; reset = (k == 3);
      @(negedge clk);
      if (k == 3) check("reset_busy stall_ex", DW'(stall_ex), '0);
      if (k == 4) begin
        check("reset_busy after mac_busy", DW'(mac_busy), '0);
        check("reset_busy after mac_out", mac_out, '0);
        check("reset_busy after stall_ex", DW'(stall_ex), '0);
      end
      next_cycle();
    end
    reset = 1'b0;
    model_acc = '0;
    idle_cycles("reset_busy", 6);
    $display("txn reset_busy: mac_out=%h expected=%h", mac_out, model_acc);

    // MEM hold with a waiting MAC, which starts only in the IDLE cycle afterwards.
    run_mac("memhold", 1'b1, 32'd6, 32'd7, 32'd42, 3, 1'b1);
    run_mac("memhold_next", 1'b0, 32'd1, 32'd1, 32'd43, 0, 1'b0);
    idle_cycles("memhold", 1);

    for (int i = 0; i < 20; i++) begin
      r_clr = 1'($urandom_range(0, 1));
      r_a   = (i % 3 == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom);
      r_b   = (i % 3 == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom);
      r_exp = r_clr ? (r_a * r_b) : (model_acc + r_a * r_b);
      run_mac($sformatf("rand%0d", i), r_clr, r_a, r_b, r_exp,
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      idle_cycles($sformatf("rand%0d", i), int'($urandom_range(1, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
